// File: rtl/rx_selio_pkg.sv
// ---------------------------------------------------------------------------
// rx_selio_pkg
//   Shared definitions for the rx_selio AXI4-Lite register block:
//   register word offsets (ADDR[3:2]), CTRL/STATUS bit positions, AXI
//   response codes, write/read channel state encodings and a byte-strobe
//   merge helper.
// ---------------------------------------------------------------------------
package rx_selio_pkg;

    // Register word index (byte address bits [3:2])
    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_SCRATCH = 2'd1;
    localparam logic [1:0] ADDR_RX_DATA = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // CTRL bits
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    // STATUS bits ([15:0] hold the FIFO level)
    localparam int STATUS_OVF_BIT   = 16;
    localparam int STATUS_EMPTY_BIT = 17;

    // AXI responses
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel: collect AW and W beats, then present B
    typedef enum logic [0:0] {
        WR_COLLECT = 1'b0,
        WR_RESP    = 1'b1
    } wr_state_t;

    // Read channel: accept AR, then present R
    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    // Merge new_val into old_val on the byte lanes enabled by strb
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rx_selio_fifo.sv
// ---------------------------------------------------------------------------
// rx_selio_fifo
//   Synchronous FIFO buffering deserialised rx words.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     push, wr_data   write request and word; ignored when full unless a pop
//                     happens in the same cycle
//     pop, rd_data    read request and head word (rd_data is the current head)
//     flush           empties the FIFO; wins over a same-cycle push/pop
//     level           current occupancy, 0..DEPTH
//     full, empty     occupancy flags
// ---------------------------------------------------------------------------
module rx_selio_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push alongside it; the level then stays put.
    assign do_pop  = pop  & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rx_selio_axil_regs.sv
// ---------------------------------------------------------------------------
// rx_selio_axil_regs
//   AXI4-Lite responder for the LVDS receive path. Holds CTRL, SCRATCH,
//   RX_DATA (pop-on-read from the rx word FIFO) and STATUS registers.
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESETN   clock, async active-low reset
//     S_AXI_AW* / W* / B*         AXI4-Lite write channels
//     S_AXI_AR* / R*              AXI4-Lite read channels
//     rx_data_i, rx_valid_i       word stream from the deserialiser
//     rx_en_o                     CTRL.enable to the deserialiser
//     irq_o                       overflow interrupt (RX_SELIO_OVF_IRQ_EN only)
//   Build option:
//     RX_SELIO_OVF_IRQ_EN  adds irq_o = STATUS.overflow (level-sensitive,
//                          cleared by the STATUS W1C write).
//   Handshake rule on every channel: a beat transfers on the rising edge
//   where both VALID and READY are high; a VALID, once raised, is held with
//   its payload stable until that edge.
//   Register map (byte address):
//     0x0 CTRL    [0] enable, [1] flush (self-clearing, reads 0)
//     0x4 SCRATCH
//     0x8 RX_DATA read pops the FIFO; SLVERR with data 0 when empty
//     0xC STATUS  [15:0] level, [16] overflow (W1C), [17] empty
// ---------------------------------------------------------------------------
module rx_selio_axil_regs
    import rx_selio_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [31:0]                     rx_data_i,
    input  logic                            rx_valid_i,
    output logic                            rx_en_o
`ifdef RX_SELIO_OVF_IRQ_EN
    ,
    output logic                            irq_o
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic        clk;
    logic        rst_n;
    assign clk   = S_AXI_ACLK;
    assign rst_n = S_AXI_ARESETN;

    // Readies stay low during reset and for the first cycle after it
    logic ready_en;

    // Write channel
    wr_state_t   wr_state, wr_state_next;
    logic        aw_held, w_held;
    logic [1:0]  awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_fire, w_fire, wr_commit;

    // Read channel
    rd_state_t   rd_state, rd_state_next;
    logic        ar_fire;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [31:0] rd_value;
    logic [1:0]  rd_resp;

    // Registers
    logic        enable;
    logic [31:0] scratch;
    logic        overflow;

    // FIFO interface
    logic          fifo_push, fifo_pop, fifo_flush;
    logic [31:0]   fifo_rd_data;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;
    logic [16:0]   level_wide;
    logic [15:0]   status_level;
    logic          ovf_set, ovf_clear;

    logic unused;
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // ---------------- write channel FSM ----------------
    assign aw_fire   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_fire    = S_AXI_WVALID  & S_AXI_WREADY;
    // Both beats captured: registers update and B is raised on this edge
    assign wr_commit = (wr_state == WR_COLLECT) & aw_held & w_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_state <= WR_COLLECT;
        else        wr_state <= wr_state_next;
    end

    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            WR_COLLECT: if (aw_held && w_held) wr_state_next = WR_RESP;
            WR_RESP:    if (S_AXI_BREADY)      wr_state_next = WR_COLLECT;
            default:    wr_state_next = WR_COLLECT;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = ready_en & (wr_state == WR_COLLECT) & ~aw_held;
        S_AXI_WREADY  = ready_en & (wr_state == WR_COLLECT) & ~w_held;
        S_AXI_BVALID  = (wr_state == WR_RESP);
        S_AXI_BRESP   = RESP_OKAY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= S_AXI_AWADDR[3:2];
                end
                if (w_fire) begin
                    w_held  <= 1'b1;
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
            end
        end
    end

    // ---------------- read channel FSM ----------------
    assign ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_state_next;
    end

    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_fire)      rd_state_next = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = ready_en & (rd_state == RD_IDLE);
        S_AXI_RVALID  = (rd_state == RD_RESP);
        S_AXI_RDATA   = rdata_q;
        S_AXI_RRESP   = rresp_q;
    end

    // Level field is 16 bits; only a 65536-deep FIFO can exceed it, so clamp
    assign level_wide   = 17'(fifo_level);
    assign status_level = level_wide[16] ? 16'hFFFF : level_wide[15:0];

    always_comb begin
        rd_value = '0;
        rd_resp  = RESP_OKAY;
        case (S_AXI_ARADDR[3:2])
            ADDR_CTRL:    rd_value[CTRL_ENABLE_BIT] = enable;
            ADDR_SCRATCH: rd_value = scratch;
            ADDR_RX_DATA: begin
                if (fifo_empty) rd_resp  = RESP_SLVERR;
                else            rd_value = fifo_rd_data;
            end
            default: begin
                rd_value[15:0]             = status_level;
                rd_value[STATUS_OVF_BIT]   = overflow;
                rd_value[STATUS_EMPTY_BIT] = fifo_empty;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rdata_q <= rd_value;
            rresp_q <= rd_resp;
        end
    end

    // ---------------- registers ----------------
    assign fifo_push  = rx_valid_i & enable;
    assign fifo_pop   = ar_fire & (S_AXI_ARADDR[3:2] == ADDR_RX_DATA) & ~fifo_empty;
    assign fifo_flush = wr_commit & (awaddr_q == ADDR_CTRL) & wstrb_q[0] & wdata_q[CTRL_FLUSH_BIT];

    // A word lost to a full FIFO sets overflow; a flush discards the push
    // outright, so it never counts as an overflow.
    assign ovf_set   = fifo_push & fifo_full & ~fifo_pop & ~fifo_flush;
    assign ovf_clear = wr_commit & (awaddr_q == ADDR_STATUS) & wstrb_q[2] & wdata_q[STATUS_OVF_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable   <= 1'b0;
            scratch  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_commit && awaddr_q == ADDR_CTRL && wstrb_q[0])
                enable <= wdata_q[CTRL_ENABLE_BIT];
            if (wr_commit && awaddr_q == ADDR_SCRATCH)
                scratch <= apply_wstrb(scratch, wdata_q, wstrb_q);
            // set wins over a same-cycle clear
            overflow <= ovf_set | (overflow & ~ovf_clear);
        end
    end

    assign rx_en_o = enable;

`ifdef RX_SELIO_OVF_IRQ_EN
    assign irq_o = overflow;
`endif

    rx_selio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (rx_data_i),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
